key_parity_monitor: RTL and testbench

- Parametrised, registered monitor for the AES datapath. Arms when the cipher state equals a programmed trigger pattern.
- Once armed, computes per round-key channel an AND-XOR parity of the low state bits against that channel's round key.
- Each channel keeps an event-rotated shift register and a saturating event counter, and raises an alarm when any counter reaches a threshold.
- Instantiated beside the AES core as an observability/regression instrument; it has no effect on cipher outputs.

---
 rtl/key_parity_monitor.sv | 152 +++++++++++++++
 tb/tb_key_parity_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_parity_monitor.sv
// key_parity_monitor: observability monitor placed beside the AES core.
// It arms when the cipher state matches TRIG_PATTERN. Once armed, each
// round-key channel computes the AND-XOR parity of the low TAP_W bits of
// state and its round key. A channel event rotates that channel's shift
// register and bumps its saturating counter. The alarm trips when any
// counter reaches THRESH.
// Optional feature macro: KPM_MASK_EN adds the trig_mask input, which
// masks the arming compare.
//
// FSM encoding is fully visible on the outputs:
//   IDLE = {armed,alarm} 00, ARMED = 10, TRIPPED = 11.
module key_parity_monitor #(
  parameter int                 N_CH         = 8,
  parameter int                 STATE_W      = 128,
  parameter int                 TAP_W        = 8,
  parameter int                 SH_W         = 8,
  parameter logic [SH_W-1:0]    SH_SEED      = SH_W'(8'hAA),
  parameter logic [STATE_W-1:0] TRIG_PATTERN = STATE_W'(128'h00112233_44556677_8899aabb_ccddeeff),
  parameter int                 CNT_W        = 16,
  parameter logic [CNT_W-1:0]   THRESH       = CNT_W'(4)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [STATE_W-1:0]       state,
`ifdef KPM_MASK_EN
  input  logic [STATE_W-1:0]       trig_mask,
`endif
  input  logic [N_CH*STATE_W-1:0]  rk_flat,
  output logic                     armed,
  output logic                     alarm,
  output logic [N_CH-1:0]          event_vec,
  output logic [N_CH*SH_W-1:0]     sh_flat,
  output logic [N_CH*CNT_W-1:0]    cnt_flat
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIPPED} fsm_t;

  fsm_t             fsm_q;
  logic             armed_q;
  logic             alarm_q;
  logic [N_CH-1:0]  event_q;
  logic [N_CH-1:0]  event_d;
  logic [SH_W-1:0]  sh_q  [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic             match;
  logic             trip;

  // Only the low TAP_W bits of each round key enter the parity.
  logic rk_unused;
  assign rk_unused = ^rk_flat;

  // Arming compare: exact, or masked when the mask feature is built in.
`ifdef KPM_MASK_EN
  assign match = ((state & trig_mask) == (TRIG_PATTERN & trig_mask));
`else
  assign match = (state == TRIG_PATTERN);
`endif

  // Per-channel parity gated by "not IDLE"; this is next cycle's event strobe.
  always_comb begin
    event_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      event_d[i] = (fsm_q != S_IDLE) &
                   (^(state[TAP_W-1:0] & rk_flat[i*STATE_W +: TAP_W]));
    end
  end

  // Trip request: any registered counter sitting exactly at THRESH.
  always_comb begin
    trip = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_q[i] == THRESH) trip = 1'b1;
    end
  end

  // Control FSM with registered armed/alarm; clear beats every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
    end else if (clear) begin
      fsm_q   <= S_IDLE;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (match) begin
            fsm_q   <= S_ARMED;
            armed_q <= 1'b1;
          end
        end
        S_ARMED: begin
          if (trip) begin
            fsm_q   <= S_TRIPPED;
            alarm_q <= 1'b1;
          end
        end
        S_TRIPPED: begin
          // Terminal until clear or rst; later pattern matches are ignored.
        end
        default: begin
          fsm_q   <= S_IDLE;
          armed_q <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  // Channel datapath: event strobe, rotate-right register, saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_q[i]  <= SH_SEED;
        cnt_q[i] <= '0;
      end
    end else if (clear) begin
      event_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_q[i]  <= SH_SEED;
        cnt_q[i] <= '0;
      end
    end else begin
      event_q <= event_d;
      for (int i = 0; i < N_CH; i++) begin
        if (event_d[i]) begin
          sh_q[i] <= {sh_q[i][0], sh_q[i][SH_W-1:1]};
          if (cnt_q[i] != {CNT_W{1'b1}}) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Flatten per-channel registers onto the output buses.
  always_comb begin
    sh_flat  = '0;
    cnt_flat = '0;
    for (int i = 0; i < N_CH; i++) begin
      sh_flat[i*SH_W +: SH_W]    = sh_q[i];
      cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign armed     = armed_q;
  assign alarm     = alarm_q;
  assign event_vec = event_q;

endmodule

// File: tb/tb_key_parity_monitor.sv
// Bench for key_parity_monitor: directed tables, hand sequences and a
// randomized run scored against an abstract channel/mode model.
module tb_key_parity_monitor;
  localparam int N_CH    = 8;
  localparam int SW      = 128;
  localparam int SH_W    = 8;
  localparam int CNT_W   = 16;
  localparam int THR     = 4;
  localparam int CNT_MAX = 65535;
  localparam logic [127:0] TRIG = 128'h00112233_44556677_8899aabb_ccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  clear;
  logic [SW-1:0]         state;
  logic [SW-1:0]         trig_mask;
  logic [N_CH*SW-1:0]    rk_flat;
  logic                  armed, alarm;
  logic [N_CH-1:0]       event_vec;
  logic [N_CH*SH_W-1:0]  sh_flat;
  logic [N_CH*CNT_W-1:0] cnt_flat;

  key_parity_monitor dut (
    .clk(clk), .rst(rst), .clear(clear), .state(state),
`ifdef KPM_MASK_EN
    .trig_mask(trig_mask),
`endif
    .rk_flat(rk_flat), .armed(armed), .alarm(alarm),
    .event_vec(event_vec), .sh_flat(sh_flat), .cnt_flat(cnt_flat)
  );

  // Narrow-counter instance for saturation.
  logic              clear2;
  logic [SW-1:0]     state2;
  logic [SW-1:0]     trig_mask2;
  logic [2*SW-1:0]   rk2;
  logic              armed2, alarm2;
  logic [1:0]        event2;
  logic [15:0]       sh2;
  logic [5:0]        cnt2;

  key_parity_monitor #(.N_CH(2), .CNT_W(3), .THRESH(3'd3)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .state(state2),
`ifdef KPM_MASK_EN
    .trig_mask(trig_mask2),
`endif
    .rk_flat(rk2), .armed(armed2), .alarm(alarm2),
    .event_vec(event2), .sh_flat(sh2), .cnt_flat(cnt2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N_CH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 armed, 2 tripped. Rotation tracked as an event count.
  int m_mode;
  int m_cnt [N_CH];
  int m_rot [N_CH];

  function automatic logic [7:0] seed_rot(input int k);
    logic [7:0] s;
    int r;
    s = 8'hAA;
    r = k % 8;
    return (s >> r) | (s << (8 - r));
  endfunction

  function automatic bit model_match();
`ifdef KPM_MASK_EN
    return (state & trig_mask) == (TRIG & trig_mask);
`else
    return state == TRIG;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = 0;
      m_rot[i] = 0;
    end
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic [N_CH-1:0] ev;
    bit any_thr;
    logic [7:0] a, b;
    ev = '0;
    if (clear) begin
      model_reset();
    end else begin
      any_thr = 0;
      for (int i = 0; i < N_CH; i++) if (m_cnt[i] == THR) any_thr = 1;
      a = state[7:0];
      for (int i = 0; i < N_CH; i++) begin
        b = rk_flat[i*SW +: 8];
        ev[i] = (m_mode != 0) && ($countones(a & b) % 2 == 1);
        if (ev[i]) begin
          if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
          m_rot[i]++;
        end
      end
      if (m_mode == 0 && model_match()) m_mode = 1;
      else if (m_mode == 1 && any_thr) m_mode = 2;
    end
    exp_q.push_back(ev);
  endtask

  task automatic check_all();
    logic [N_CH-1:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1 @%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_vec", event_vec, e);
    end
    chk("armed", armed, m_mode != 0);
    chk("alarm", alarm, m_mode == 2);
    for (int i = 0; i < N_CH; i++) begin
      chk($sformatf("cnt%0d", i), cnt_flat[i*CNT_W +: CNT_W], m_cnt[i]);
      chk($sformatf("sh%0d", i), sh_flat[i*SH_W +: SH_W], seed_rot(m_rot[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_rk(input logic [7:0] rk0, input logic [7:0] rko);
    rk_flat = '0;
    rk_flat[7:0] = rk0;
    for (int i = 1; i < N_CH; i++) rk_flat[i*SW +: 8] = rko;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]      st;
    logic [7:0]      rk0;
    logic [7:0]      rko;
    logic [N_CH-1:0] ev;
    logic [15:0]     cnt0;
    logic [7:0]      sh0;
    logic            al;
  } vec_t;

  vec_t tab [12];

  initial begin
    tab[0]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd1, 8'h55, 1'b0};
    tab[1]  = '{8'h03, 8'h03, 8'h00, 8'h00, 16'd1, 8'h55, 1'b0};
    tab[2]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd2, 8'hAA, 1'b0};
    tab[3]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd3, 8'h55, 1'b0};
    tab[4]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd4, 8'hAA, 1'b0};
    tab[5]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd5, 8'h55, 1'b1};
    tab[6]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd6, 8'hAA, 1'b1};
    tab[7]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd7, 8'h55, 1'b1};
    tab[8]  = '{8'h01, 8'h01, 8'h00, 8'h01, 16'd8, 8'hAA, 1'b1};
    tab[9]  = '{8'h03, 8'h03, 8'h00, 8'h00, 16'd8, 8'hAA, 1'b1};
    tab[10] = '{8'h01, 8'h01, 8'h01, 8'hFF, 16'd9, 8'h55, 1'b1};
    tab[11] = '{8'h03, 8'h03, 8'h01, 8'hFE, 16'd9, 8'h55, 1'b1};

    // Reset values, observed while rst is still asserted.
    rst = 1'b1; clear = 1'b0; state = '0; rk_flat = '0; trig_mask = '1;
    clear2 = 1'b0; state2 = '0; rk2 = '0; trig_mask2 = '1;
    #2;
    chk("rst_sh", sh_flat, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rst_cnt", cnt_flat, '0);
    chk("rst_armed", armed, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_event", event_vec, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Arming: reversed-nibble pattern must not arm, exact pattern must.
    state = 128'hffeeddcc_bbaa9988_77665544_33221100;
    for (int i = 0; i < N_CH; i++) rk_flat[i*SW +: SW] = 128'hFF;
    cycle();
    chk("no_arm_swapped", armed, 1'b0);
    state = TRIG;
    cycle();
    chk("arm_on_match", armed, 1'b1);
    chk("no_event_on_match", event_vec, '0);

    // Parity / rotate / alarm / simultaneous channels.
    for (int k = 0; k < 12; k++) begin
      state = {120'h0, tab[k].st};
      set_rk(tab[k].rk0, tab[k].rko);
      cycle();
      chk($sformatf("tab%0d_ev", k), event_vec, tab[k].ev);
      chk($sformatf("tab%0d_cnt0", k), cnt_flat[15:0], tab[k].cnt0);
      chk($sformatf("tab%0d_sh0", k), sh_flat[7:0], tab[k].sh0);
      chk($sformatf("tab%0d_alarm", k), alarm, tab[k].al);
    end

    // Clear together with a pattern match in TRIPPED -> IDLE, re-arm later.
    clear = 1'b1; state = TRIG;
    cycle();
    chk("clr_armed", armed, 1'b0);
    chk("clr_alarm", alarm, 1'b0);
    chk("clr_cnt", cnt_flat, '0);
    clear = 1'b0;
    cycle();
    chk("rearm", armed, 1'b1);

    // Build up some state, then reset in the middle of a clock phase.
    state = 128'h1; set_rk(8'h01, 8'h01);
    repeat (3) cycle();
    #3 rst = 1'b1;
    #1;
    chk("midrst_sh", sh_flat, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("midrst_cnt", cnt_flat, '0);
    chk("midrst_armed", armed, 1'b0);
    chk("midrst_alarm", alarm, 1'b0);
    chk("midrst_event", event_vec, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      clear = ($urandom_range(0, 29) == 0);
      state = ($urandom_range(0, 5) == 0) ? TRIG : {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < N_CH; i++)
        rk_flat[i*SW +: SW] = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    clear = 1'b0;

`ifdef KPM_MASK_EN
    // All-zero mask arms on the first clock after clear.
    trig_mask = '0;
    clear = 1'b1; state = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    chk("mask_clr_armed", armed, 1'b0);
    clear = 1'b0; state = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    chk("mask_zero_arms", armed, 1'b1);
    trig_mask = '1;
`endif

    // Saturation on the 3-bit counter instance: 20 events, THRESH=3.
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    state2 = TRIG;
    @(posedge clk);
    #1;
    chk("sat_armed", armed2, 1'b1);
    state2 = 128'h1;
    rk2 = '0;
    rk2[7:0] = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt_%0d", k), cnt2[2:0], (k > 7) ? 7 : k);
      chk($sformatf("sat_alarm_%0d", k), alarm2, k >= 4);
    end
    chk("sat_ch1_idle", cnt2[5:3], 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
